// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS memory-access stage:
// instruction field positions, FSM states and access kinds.
package mips_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  // Store wins over fetch, fetch wins over load.
  function automatic kind_t pick_kind(input logic irw, input logic mw);
    kind_t k;
    if (mw) begin
      k = K_STORE;
    end else if (irw) begin
      k = K_FETCH;
    end else begin
      k = K_LOAD;
    end
    return k;
  endfunction

  function automatic logic multi_strobe(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit BUSY-cycle counter; expired flags the last permitted wait cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  // Clear has priority so a new transaction always starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_iface_unit.sv
// Memory-access stage: converts controller strobes into one req/ack bus
// transaction, latches IR/MDR and stalls the controller while pending.
module mem_iface_unit
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iord,
  input  logic              irwrite,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              bus_err,
  output logic              proto_err
);

  state_t              r_state;
  state_t              w_next_state;
  kind_t               r_kind;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_bus_err;
  logic                r_proto_err;
  logic                w_start;
  logic                w_launch;
  logic                w_busy;
  logic                w_expired;
  logic                w_stall;

  assign w_start  = irwrite | memread | memwrite;
  assign w_launch = (r_state == S_IDLE) & w_start;
  assign w_busy   = (r_state == S_BUSY);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_launch),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and stall; an ack on the expiring cycle still counts as success.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_BUSY;
          w_stall      = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (mem_ack || w_expired) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_BUSY;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Bus request side: latch the winning access at launch, release on ack or abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_kind      <= K_FETCH;
      r_bus_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (w_launch) begin
      r_req   <= 1'b1;
      r_we    <= memwrite;
      r_addr  <= iord ? aluout : pc;
      r_wdata <= wdata;
      r_kind  <= pick_kind(irwrite, memwrite);
      if (multi_strobe(irwrite, memread, memwrite)) begin
        r_proto_err <= 1'b1;
      end
    end else if (w_busy && (mem_ack || w_expired)) begin
      r_req <= 1'b0;
      if (!mem_ack) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Read-data capture; acks outside BUSY are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
      r_mdr   <= '0;
    end else if (w_busy && mem_ack) begin
      if (r_kind == K_FETCH) begin
        r_instr <= mem_rdata;
      end else if (r_kind == K_LOAD) begin
        r_mdr <= mem_rdata;
      end
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign instr     = r_instr;
  assign op        = r_instr[OP_MSB:OP_LSB];
  assign funct     = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign mdr       = r_mdr;
  assign stall     = w_stall;
  assign bus_err   = r_bus_err;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_iface_unit.sv
// Self-checking bench for mem_iface_unit: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_mem_iface_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        iord, irwrite, memread, memwrite;
  logic [31:0] pc, aluout, wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instr, mdr;
  logic [5:0]  op, funct;
  logic        stall, bus_err, proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_instr, m_mdr;
  logic        m_bus_err, m_proto_err;

  mem_iface_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .iord      (iord),
    .irwrite   (irwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .pc        (pc),
    .aluout    (aluout),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .instr     (instr),
    .op        (op),
    .funct     (funct),
    .mdr       (mdr),
    .stall     (stall),
    .bus_err   (bus_err),
    .proto_err (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_instr"}, instr, m_instr);
    chk({tag, "_mdr"}, mdr, m_mdr);
    chk({tag, "_op"}, {26'd0, op}, {26'd0, m_instr[31:26]});
    chk({tag, "_funct"}, {26'd0, funct}, {26'd0, m_instr[5:0]});
    chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, m_bus_err});
    chk({tag, "_proto_err"}, {31'd0, proto_err}, {31'd0, m_proto_err});
  endtask

  // One controller access; ack_at = BUSY cycle (1-based) carrying the ack, 0 = never.
  task automatic run_txn(input string tag, input logic irw, input logic mr, input logic mw,
                         input logic io, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input bit scramble);
    int  n_stall;
    int  exp_stall;
    int  nstrobe;
    bit  done;
    bit  acked;
    bit  is_store;
    bit  is_fetch;
    irwrite = irw; memread = mr; memwrite = mw;
    iord = io; pc = p; aluout = a; wdata = wd;
    n_stall = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!done) begin
        #1;
        if (stall) begin
          n_stall++;
          chk({tag, "_req_during_stall"}, {31'd0, mem_req}, (cyc >= 1) ? 32'd1 : 32'd0);
          if (cyc >= 1 && cyc == ack_at) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
          end
          if (cyc >= 1 && scramble) begin
            pc = $urandom; aluout = $urandom; wdata = $urandom; iord = ~iord;
          end
          @(negedge clk);
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end else begin
          done = 1'b1;
        end
      end
    end
    chk({tag, "_reached_done"}, {31'd0, done}, 32'd1);

    nstrobe  = int'(irw) + int'(mr) + int'(mw);
    is_store = mw;
    is_fetch = !mw && irw;
    acked    = (ack_at >= 1) && (ack_at <= TO);
    exp_stall = 1 + (acked ? ack_at : TO);
    if (nstrobe > 1) m_proto_err = 1'b1;
    if (!acked) m_bus_err = 1'b1;
    else if (is_fetch) m_instr = rd;
    else if (!is_store) m_mdr = rd;

    chk({tag, "_stall_cycles"}, n_stall, exp_stall);
    chk({tag, "_req_done"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_addr"}, mem_addr, io ? a : p);
    chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, is_store});
    if (is_store) chk({tag, "_wdata"}, mem_wdata, wd);
    chk_state(tag);

    // Strobes left high through DONE must not start a new access.
    @(negedge clk);
    irwrite = 1'b0; memread = 1'b0; memwrite = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    logic [31:0] r_rd;
    int          kind;
    reset = 1'b0;
    iord = 1'b0; irwrite = 1'b0; memread = 1'b0; memwrite = 1'b0;
    pc = '0; aluout = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    m_instr = '0; m_mdr = '0; m_bus_err = 1'b0; m_proto_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk_state("rst");
    reset = 1'b1;
    @(negedge clk);

    run_txn("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 32'h8C220004, 1'b0);
    chk("fetch_op_const", {26'd0, op}, 32'h23);
    chk("fetch_funct_const", {26'd0, funct}, 32'h04);
    run_txn("load", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    chk("load_mdr_const", mdr, 32'hDEADBEEF);
    run_txn("store", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h104, 32'h12345678, 2, 32'hCAFEF00D, 1'b0);
    chk("store_wdata_const", mem_wdata, 32'h12345678);

    // Stray ack while idle: nothing captured.
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk_state("stray_ack");

    run_txn("conflict", 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h200, 32'h0BADF00D, 1, 32'h11112222, 1'b0);
    chk("conflict_proto_const", {31'd0, proto_err}, 32'd1);
    run_txn("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    chk("timeout_bus_err_const", {31'd0, bus_err}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(1, 7));
      r_rd = $urandom;
      run_txn("rand", kind[0], kind[1], kind[2], 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, int'($urandom_range(0, 6)), r_rd, 1'b1);
    end

    // Reset asserted in the middle of a BUSY wait.
    irwrite = 1'b1; iord = 1'b0; pc = 32'h500;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    irwrite = 1'b0;
    #1;
    m_instr = '0; m_mdr = '0; m_bus_err = 1'b0; m_proto_err = 1'b0;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk_state("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_txn("post_rst_fetch", 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 2, 32'h01234567, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
